// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC-driven memory reads, a small credit-managed
// instruction FIFO and a valid/ready hand-off to decode, with branch redirect.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'd0,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        mem_busy,
    output logic        MemRead,
    output logic [15:0] ADDR,
    input  logic [15:0] Data_out,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc
);

    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = PW + 1;
    localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;
    localparam logic [15:0] PC_LAST     = 16'(MEM_WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [15:0]   word_q [FIFO_DEPTH];
    logic [15:0]   wpc_q  [FIFO_DEPTH];

    logic          issue, push, pop;
    logic [CW:0]   credit;
    logic [15:0]   redirect_pc_mod;

    assign redirect_pc_mod = 16'(32'(redirect_pc) % MEM_WORDS_U);

    // Outputs read the FIFO head; empty FIFO drives zeros.
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? word_q[rd_ptr_q] : 16'd0;
    assign instr_pc    = instr_valid ? wpc_q[rd_ptr_q]  : 16'd0;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        pop  = instr_valid && instr_ready && !redirect;
        push = inflight_q && !kill_q && !redirect;

        // Credit counts words held plus the one still in the memory pipeline.
        credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue  = (state_q == RUN) && fetch_en && !mem_busy && !redirect &&
                 (credit < (CW + 1)'(FIFO_DEPTH));

        MemRead = issue;
        ADDR    = issue ? pc_q : 16'd0;

        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        inflight_d = issue;
        kill_d     = redirect && inflight_q;
        if (issue) begin
            inflight_pc_d = pc_q;
        end

        if (redirect) begin
            pc_d     = redirect_pc_mod;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d = (pc_q == PC_LAST) ? 16'd0 : pc_q + 16'd1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'd0;
            kill_q        <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            word_q[wr_ptr_q] <= Data_out;
            wpc_q[wr_ptr_q]  <= inflight_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (reset)
        !(push && !pop && count_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table plus hand sequences for
// stall, redirect-with-inflight and asynchronous reset.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        fetch_en, mem_busy, MemRead, redirect, instr_valid, instr_ready;
    logic [15:0] ADDR, Data_out, redirect_pc, instr, instr_pc;

    logic [15:0] mem [1024];
    logic [15:0] rdata = 16'd0;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(.RESET_PC(16'd0), .MEM_WORDS(1024), .FIFO_DEPTH(2)) dut (
        .CLK(CLK), .reset(reset), .fetch_en(fetch_en), .mem_busy(mem_busy),
        .MemRead(MemRead), .ADDR(ADDR), .Data_out(Data_out),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 CLK = ~CLK;

    // Memory model: synchronous read, data held until the next read.
    always @(posedge CLK) begin
        if (MemRead) rdata <= mem[ADDR[9:0]];
    end
    assign Data_out = rdata;

    typedef struct {
        logic        fe, busy, redir;
        logic [15:0] rpc;
        logic        rdy;
        logic        mr;
        logic [15:0] addr;
        logic        v;
        logic [15:0] ins, ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fe, logic busy, logic redir, logic [15:0] rpc, logic rdy,
                                logic mr, logic [15:0] addr, logic v, logic [15:0] ins,
                                logic [15:0] ipc);
        vec_t r;
        r.fe = fe; r.busy = busy; r.redir = redir; r.rpc = rpc; r.rdy = rdy;
        r.mr = mr; r.addr = addr; r.v = v; r.ins = ins; r.ipc = ipc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic fe, input logic busy, input logic redir,
                         input logic [15:0] rpc, input logic rdy);
        fetch_en = fe; mem_busy = busy; redirect = redir; redirect_pc = rpc; instr_ready = rdy;
    endtask

    // Leaves the bench 1 time unit after a posedge with reset just released (cycle c0).
    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic mr, input logic [15:0] addr,
                           input logic v, input logic [15:0] ins, input logic [15:0] ipc);
        chk({tag, "_memread"}, {15'd0, MemRead}, {15'd0, mr});
        chk({tag, "_addr"}, ADDR, addr);
        chk({tag, "_valid"}, {15'd0, instr_valid}, {15'd0, v});
        chk({tag, "_instr"}, instr, ins);
        chk({tag, "_pc"}, instr_pc, ipc);
        $display("%s: MemRead=%b ADDR=%h valid=%b instr=%h pc=%h",
                 tag, MemRead, ADDR, instr_valid, instr, instr_pc);
    endtask

    int reads;
    logic [15:0] addrs [2];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h2427; mem[1] = 16'h6FA7; mem[2] = 16'h4901; mem[3] = 16'h9201;

        //          fe busy rd rpc      rdy  mr addr     v ins       ipc
        vecs.push_back(mk(1,0,0,16'h0000,1, 0,16'h000,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h000,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h001,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h002,1,16'h2427,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h003,1,16'h6FA7,16'h001));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h004,1,16'h4901,16'h002));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h005,1,16'h9201,16'h003));
        vecs.push_back(mk(1,0,0,16'h0000,0, 0,16'h000,1,16'h1004,16'h004));
        vecs.push_back(mk(1,0,0,16'h0000,0, 0,16'h000,1,16'h1004,16'h004));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h006,1,16'h1004,16'h004));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h007,1,16'h1005,16'h005));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h008,1,16'h1006,16'h006));
        vecs.push_back(mk(1,1,0,16'h0000,1, 0,16'h000,1,16'h1007,16'h007));
        vecs.push_back(mk(1,1,0,16'h0000,1, 0,16'h000,1,16'h1008,16'h008));
        vecs.push_back(mk(1,1,0,16'h0000,1, 0,16'h000,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h009,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h00A,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h00B,1,16'h1009,16'h009));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h00C,1,16'h100A,16'h00A));
        vecs.push_back(mk(1,0,1,16'h03FF,1, 0,16'h000,1,16'h100B,16'h00B));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h3FF,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h000,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h001,1,16'h13FF,16'h3FF));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h002,1,16'h2427,16'h000));
        vecs.push_back(mk(1,0,1,16'h0405,1, 0,16'h000,1,16'h6FA7,16'h001));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h005,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h006,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h007,1,16'h1005,16'h005));
        vecs.push_back(mk(1,0,1,16'h0100,1, 0,16'h000,1,16'h1006,16'h006));
        vecs.push_back(mk(1,0,1,16'h0200,1, 0,16'h000,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h200,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h201,0,16'h0000,16'h000));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h202,1,16'h1200,16'h200));
        vecs.push_back(mk(0,0,0,16'h0000,1, 0,16'h000,1,16'h1201,16'h201));
        vecs.push_back(mk(1,0,0,16'h0000,1, 0,16'h000,1,16'h1202,16'h202));
        vecs.push_back(mk(1,0,0,16'h0000,1, 1,16'h203,0,16'h0000,16'h000));

        // Reset state with fetching requested.
        reset = 1'b1;
        drive(1, 0, 0, 16'h0000, 1);
        #3;
        chk_out("reset", 0, 16'h0000, 0, 16'h0000, 16'h0000);

        // Main cycle table.
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) next_cycle();
            drive(vecs[i].fe, vecs[i].busy, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            #2;
            chk_out($sformatf("vec%0d", i), vecs[i].mr, vecs[i].addr, vecs[i].v,
                    vecs[i].ins, vecs[i].ipc);
        end

        // Decode stalled from the start: only two reads may be issued.
        drive(1, 0, 0, 16'h0000, 0);
        do_reset();
        reads = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            #2;
            if (MemRead) begin
                if (reads < 2) addrs[reads] = ADDR;
                reads++;
            end
        end
        chk("stall_reads", 16'(reads), 16'd2);
        chk("stall_addr0", addrs[0], 16'h0000);
        chk("stall_addr1", addrs[1], 16'h0001);
        chk_out("stall_hold", 0, 16'h0000, 1, 16'h2427, 16'h0000);
        next_cycle();
        drive(1, 0, 0, 16'h0000, 1);
        #2;
        chk_out("drain0", 1, 16'h0002, 1, 16'h2427, 16'h0000);
        next_cycle();
        #2;
        chk_out("drain1", 1, 16'h0003, 1, 16'h6FA7, 16'h0001);
        next_cycle();
        #2;
        chk_out("drain2", 1, 16'h0004, 1, 16'h4901, 16'h0002);

        // Redirect to 6 while the read of address 3 is returning.
        drive(1, 0, 0, 16'h0000, 1);
        do_reset();
        for (int c = 1; c < 5; c++) next_cycle();
        #2;
        chk_out("rd_pre", 1, 16'h0003, 1, 16'h6FA7, 16'h0001);
        next_cycle();
        drive(1, 0, 1, 16'h0006, 1);
        #2;
        chk_out("rd_cyc", 0, 16'h0000, 1, 16'h4901, 16'h0002);
        next_cycle();
        drive(1, 0, 0, 16'h0000, 1);
        #2;
        chk_out("rd_p1", 1, 16'h0006, 0, 16'h0000, 16'h0000);
        next_cycle();
        #2;
        chk_out("rd_p2", 1, 16'h0007, 0, 16'h0000, 16'h0000);
        next_cycle();
        #2;
        chk_out("rd_p3", 1, 16'h0008, 1, 16'h1006, 16'h0006);

        // Asynchronous reset between clock edges while streaming.
        reset = 1'b1;
        #1;
        chk_out("async_rst", 0, 16'h0000, 0, 16'h0000, 16'h0000);
        chk("async_count", 16'(dut.count_q), 16'd0);
        next_cycle();
        #2;
        chk_out("rst_hold", 0, 16'h0000, 0, 16'h0000, 16'h0000);
        reset = 1'b0;
        #1;
        chk_out("rst_c0", 0, 16'h0000, 0, 16'h0000, 16'h0000);
        next_cycle();
        #2;
        chk_out("rst_c1", 1, 16'h0000, 0, 16'h0000, 16'h0000);
        next_cycle();
        #2;
        chk_out("rst_c2", 1, 16'h0001, 0, 16'h0000, 16'h0000);
        next_cycle();
        #2;
        chk_out("rst_c3", 1, 16'h0002, 1, 16'h2427, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
